phy_mdio_init: RTL
==================

# phy_mdio_init

PHY bring-up sequencer for the RGMII Ethernet path. After reset it holds the PHY in hardware reset, releases it, and waits for the PHY to come up. It then issues a parameterised list of Clause-22 MDIO register writes (e.g. RGMII internal delay, autoneg advertisement) and flags completion. It sits in the top level beside the PHY reset pin, runs on the 125 MHz core clock, and needs an I/O tristate buffer outside it on the MDIO pad.

## Interface
- `RESET_CYCLES`, default 1250000: cycles `phy_reset_n` is held low (10 ms at 125 MHz); must be ≥1.
- `WAIT_CYCLES`, default 6250000: cycles between reset release and the first MDIO frame (50 ms); must be ≥1.
- `MDC_DIV`, default 25: clock cycles per MDC half-period (2.5 MHz MDC); must be ≥1.
- `PHY_ADDR`, default 5'd0: PHY address used in every frame.
- `CFG_COUNT`, default 0: number of table entries to write, 0..4.
- `CFG_TABLE`, default 84'd0: 4 entries × 21 bits; entry i at [21i+20:21i] = {reg_addr[4:0], data[15:0]}.
- `clk`, input, 1: core clock, 125 MHz.
- `rst`, input, 1: synchronous active-high reset.
- `start`, input, 1: single-cycle pulse that re-runs the full sequence; honoured only in DONE.
- `phy_reset_n`, output, 1: PHY hardware reset, active low.
- `mdc`, output, 1: MDIO management clock.
- `mdio_o`, output, 1: MDIO output data.
- `mdio_t`, output, 1: MDIO tristate control; 1 releases the line (high-Z), 0 drives `mdio_o`.
- `busy`, output, 1: high while the sequence is running.
- `done`, output, 1: high once all writes are complete; stays high until `rst` or an accepted `start`.

## Operation
- All outputs are registered. Values during and immediately after reset: `phy_reset_n`=0, `mdc`=0, `mdio_o`=1, `mdio_t`=1, `busy`=1, `done`=0.
- The sequence starts automatically when `rst` deasserts.
- States:
  - RST_ASSERT: `phy_reset_n`=0 for RESET_CYCLES, then go to RST_WAIT.
  - RST_WAIT: `phy_reset_n`=1 for WAIT_CYCLES. Then go to FRAME with entry index 0, or straight to DONE if CFG_COUNT=0.
  - FRAME: shift one 64-bit write frame, then go to GAP.
  - GAP: one idle bit period (2·MDC_DIV cycles) with `mdio_t`=1 and `mdc`=0. Then increment the index; go to FRAME if index < CFG_COUNT, otherwise DONE.
  - DONE: `busy`=0, `done`=1, `mdio_t`=1, `phy_reset_n`=1. An accepted `start` clears `done`, sets `busy`, and goes to RST_ASSERT.
- Frame bit order, first to last, each field MSB first:
  - 32 × '1' (preamble)
  - ST = 01
  - OP = 01 (write)
  - PHY_ADDR[4:0]
  - reg_addr[4:0]
  - TA = 10
  - data[15:0]
- `mdio_t`=0 for all 64 bits of a frame.
- `start` outside DONE is ignored.
- `rst` asserted at any point, including mid-frame, returns the block to RST_ASSERT with the reset values on the next edge. No partial-frame completion.
- Internal counter widths are sized with `$clog2` of the largest count. Counters must not wrap for any legal parameter value.

## Timing
- Cycle 0 is the first rising edge with `rst` low.
- `phy_reset_n` goes high at cycle RESET_CYCLES.
- Frame 0, bit 0 is presented at cycle T0 = RESET_CYCLES + WAIT_CYCLES.
- Bit k of frame n starts at cycle T0 + n·130·MDC_DIV + 2k·MDC_DIV.
- Within each bit period:
  - At the bit start, `mdc`=0 and `mdio_o` takes the new bit value; the two change on the same edge.
  - At bit start + MDC_DIV, `mdc`=1.
  - At bit start + 2·MDC_DIV, the next bit starts.
- `mdio_o` is therefore stable for MDC_DIV cycles before and after each MDC rising edge.
- `mdc` is 0 outside FRAME.
- `done` rises and `busy` falls at cycle T0 + CFG_COUNT·130·MDC_DIV.
- Latency from an accepted `start` (sampled at cycle s) to `phy_reset_n`=0: cycle s+1. All later events are offset from s+1 exactly as they are from cycle 0 after reset.

## Test plan
Unless a scenario says otherwise, parameters are RESET_CYCLES=10, WAIT_CYCLES=20, MDC_DIV=2, PHY_ADDR=1, CFG_COUNT=2, entry0={0x00, 0x1140}, entry1={0x1F, 0x0D08}.

- Reset release → `phy_reset_n`=0 for cycles 0..9 and 1 from cycle 10. The first `mdio_t` fall is at cycle 30. `done` rises at cycle 550, with `busy` falling the same cycle.
- Frame capture: sample `mdio_o` on each `mdc` rising edge.
  - Frame 0 must decode to preamble 32×1, 01, 01, 00001, 00000, 10, 0x1140.
  - Frame 1 must decode to the same header with reg 11111 and data 0x0D08.
  - Each frame has exactly 64 `mdc` rising edges.
  - Each `mdc` high and low phase lasts exactly 2 cycles.
- CFG_COUNT=0 → no `mdc` edges at all, `mdio_t` stays 1, and `done` rises at cycle 30.
- Pulse `start` at cycle 200 (mid-frame) → no effect. Pulse `start` at cycle 600 (in DONE) → `done`=0, `busy`=1, and `phy_reset_n`=0 at cycle 601. `done` rises again at cycle 1151.
- Assert `rst` at cycle 100 (during frame 0) for one cycle → the next cycle shows all reset values. The full sequence then restarts from the new cycle 0, and both frames are emitted intact.
- MDC_DIV=1 → the `mdc` period is 2 cycles and `done` rises at cycle 30 + 2·130 = 290.

Source files
------------

// File: rtl/phy_mdio_init.sv
// PHY bring-up sequencer: pulses the PHY hardware reset, waits for the PHY to
// boot, then writes a fixed table of Clause-22 registers over MDIO.
module phy_mdio_init #(
  parameter int unsigned RESET_CYCLES = 1250000,
  parameter int unsigned WAIT_CYCLES  = 6250000,
  parameter int unsigned MDC_DIV      = 25,
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter int unsigned CFG_COUNT    = 0,
  parameter logic [83:0] CFG_TABLE    = 84'd0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic phy_reset_n,
  output logic mdc,
  output logic mdio_o,
  output logic mdio_t,
  output logic busy,
  output logic done
);

  localparam int unsigned BitCycles = 2 * MDC_DIV;
  localparam int unsigned RwMax     = (RESET_CYCLES > WAIT_CYCLES) ? RESET_CYCLES : WAIT_CYCLES;
  localparam int unsigned CntMax    = (RwMax > BitCycles) ? RwMax : BitCycles;
  localparam int unsigned CntW      = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] RstLast  = CntW'(RESET_CYCLES - 1);
  localparam logic [CntW-1:0] WaitLast = CntW'(WAIT_CYCLES - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(MDC_DIV - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(BitCycles - 1);
  localparam logic [2:0]      CfgCount = 3'(CFG_COUNT);

  typedef enum logic [2:0] {StRstAssert, StRstWait, StFrame, StGap, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;     // cycle counter shared by reset, wait and bit timing
  logic [5:0]      bit_q;     // index of the bit currently on the wire
  logic [2:0]      idx_q;     // table entry being written
  logic [63:0]     shift_q;   // remaining frame bits, next one at [63]
  logic [2:0]      idx_nxt;
  logic [63:0]     load_word;

  // Build the 64-bit write frame for table entry i.
  function automatic logic [63:0] frame_word(input logic [1:0] i);
    logic [20:0] e;
    e = CFG_TABLE[21 * int'(i) +: 21];
    return {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, e[20:16], 2'b10, e[15:0]};
  endfunction

  assign idx_nxt   = idx_q + 3'd1;
  // From RST_WAIT the first entry is loaded; from GAP the following one.
  assign load_word = frame_word((state_q == StGap) ? idx_nxt[1:0] : 2'd0);

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRstAssert;
      cnt_q       <= '0;
      bit_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      phy_reset_n <= 1'b0;
      mdc         <= 1'b0;
      mdio_o      <= 1'b1;
      mdio_t      <= 1'b1;
      busy        <= 1'b1;
      done        <= 1'b0;
    end else begin
      unique case (state_q)
        StRstAssert: begin
          if (cnt_q == RstLast) begin
            cnt_q       <= '0;
            phy_reset_n <= 1'b1;
            state_q     <= StRstWait;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRstWait: begin
          if (cnt_q == WaitLast) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (CFG_COUNT == 0) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              bit_q   <= '0;
              shift_q <= {load_word[62:0], 1'b0};
              mdio_o  <= load_word[63];
              mdio_t  <= 1'b0;
              mdc     <= 1'b0;
              state_q <= StFrame;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFrame: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            mdc   <= 1'b0;
            if (bit_q == 6'd63) begin
              mdio_o  <= 1'b1;
              mdio_t  <= 1'b1;
              state_q <= StGap;
            end else begin
              bit_q   <= bit_q + 6'd1;
              mdio_o  <= shift_q[63];
              shift_q <= {shift_q[62:0], 1'b0};
            end
          end else begin
            // MDC rises mid-bit so data has a full half period of setup and hold.
            if (cnt_q == HalfLast) begin
              mdc <= 1'b1;
            end
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            idx_q <= idx_nxt;
            if (idx_nxt < CfgCount) begin
              bit_q   <= '0;
              shift_q <= {load_word[62:0], 1'b0};
              mdio_o  <= load_word[63];
              mdio_t  <= 1'b0;
              state_q <= StFrame;
            end else begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= StDone;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (start) begin
            state_q     <= StRstAssert;
            cnt_q       <= '0;
            idx_q       <= '0;
            phy_reset_n <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        default: state_q <= StRstAssert;
      endcase
    end
  end

endmodule
